// File: rtl/johnson_pkg.sv
// rtl/johnson_pkg.sv - shared types and Johnson code helper functions
package johnson_pkg;

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} lock_state_e;

  localparam int MAXW = 32;

  function automatic int johnson_idxw(input int n);
    return $clog2(2 * n);
  endfunction

  // Legal words are a run of ones anchored at bit 0, or its complement within n bits.
  function automatic logic johnson_is_legal(input logic [MAXW-1:0] code, input int n);
    logic [MAXW-1:0] mask;
    logic [MAXW-1:0] c;
    logic [MAXW-1:0] inv;
    mask = (n >= MAXW) ? '1 : ((MAXW'(1) << n) - MAXW'(1));
    c    = code & mask;
    inv  = ~c & mask;
    return ((c & (c + MAXW'(1))) == '0) || ((inv & (inv + MAXW'(1))) == '0);
  endfunction

  function automatic int johnson_to_index(input logic [MAXW-1:0] code, input int n);
    int pop;
    pop = 0;
    for (int i = 0; i < MAXW; i++) begin
      if (i < n && code[i]) pop++;
    end
    return code[n-1] ? (2 * n - pop) : pop;
  endfunction

endpackage

// File: rtl/johnson_decoder_classify.sv
// rtl/johnson_decoder_classify.sv - combinational legality check and index decode
module johnson_code_classify
  import johnson_pkg::*;
#(
  parameter int N    = 4,
  parameter int IDXW = $clog2(2 * N)
) (
  input  logic [N-1:0]    code_i,
  output logic            legal_o,
  output logic [IDXW-1:0] index_o
);

  logic [MAXW-1:0] code_ext;

  assign code_ext = MAXW'(code_i);
  assign legal_o  = johnson_is_legal(code_ext, N);
  assign index_o  = IDXW'(johnson_to_index(code_ext, N));

endmodule

// File: rtl/johnson_decoder.sv
// rtl/johnson_decoder.sv - Johnson code decoder with sequence lock FSM and error counter
module johnson_decoder
  import johnson_pkg::*;
#(
  parameter int N          = 4,
  parameter int LOCK_COUNT = 2,
  parameter int ALLOW_HOLD = 1,
  parameter int ERRW       = 8,
  localparam int IDXW      = johnson_idxw(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    code_in,
  input  logic            code_valid,
  input  logic            clr_err,
  output logic [IDXW-1:0] index_out,
  output logic            index_valid,
  output logic            illegal,
  output logic            seq_err,
  output logic            locked,
  output logic [ERRW-1:0] err_count
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(2 * N - 1);
  localparam logic [ERRW-1:0] ERR_MAX  = '1;
  localparam logic [3:0]      LOCK_RUN = 4'(LOCK_COUNT);

  lock_state_e     state_q;
  logic [3:0]      run_q;
  logic [IDXW-1:0] prev_q;
  logic            prev_vld_q;
  logic [IDXW-1:0] index_q;
  logic            index_valid_q;
  logic            illegal_q;
  logic            seq_err_q;
  logic [ERRW-1:0] err_q;

  logic            legal;
  logic [IDXW-1:0] idx;
  logic [IDXW-1:0] next_exp_d;
  logic            succ_d;
  logic            err_event_d;
  logic [3:0]      run_inc_d;

  johnson_code_classify #(.N(N), .IDXW(IDXW)) u_classify (
    .code_i  (code_in),
    .legal_o (legal),
    .index_o (idx)
  );

  // A stalled counter repeats its word; ALLOW_HOLD decides whether that is tolerated.
  assign next_exp_d  = (prev_q == LAST_IDX) ? '0 : prev_q + IDXW'(1);
  assign succ_d      = prev_vld_q && ((idx == next_exp_d) || ((ALLOW_HOLD != 0) && (idx == prev_q)));
  assign err_event_d = code_valid && (!legal || ((state_q == LOCKED) && !succ_d));
  assign run_inc_d   = run_q + 4'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= HUNT;
      run_q         <= '0;
      prev_q        <= '0;
      prev_vld_q    <= 1'b0;
      index_q       <= '0;
      index_valid_q <= 1'b0;
      illegal_q     <= 1'b0;
      seq_err_q     <= 1'b0;
      err_q         <= '0;
    end else begin
      index_valid_q <= 1'b0;
      illegal_q     <= 1'b0;
      seq_err_q     <= 1'b0;

      if (clr_err) begin
        err_q <= '0;
      end else if (err_event_d && (err_q != ERR_MAX)) begin
        err_q <= err_q + ERRW'(1);
      end

      if (code_valid) begin
        if (!legal) begin
          illegal_q  <= 1'b1;
          state_q    <= HUNT;
          run_q      <= '0;
          prev_vld_q <= 1'b0;
        end else begin
          index_q       <= idx;
          index_valid_q <= 1'b1;
          prev_q        <= idx;
          prev_vld_q    <= 1'b1;
          case (state_q)
            HUNT: begin
              if (succ_d) begin
                run_q <= run_inc_d;
                if (run_inc_d >= LOCK_RUN) state_q <= LOCKED;
              end else begin
                run_q <= '0;
              end
            end
            LOCKED: begin
              if (!succ_d) begin
                seq_err_q <= 1'b1;
                state_q   <= HUNT;
                run_q     <= '0;
              end
            end
            default: state_q <= HUNT;
          endcase
        end
      end
    end
  end

  assign index_out   = index_q;
  assign index_valid = index_valid_q;
  assign illegal     = illegal_q;
  assign seq_err     = seq_err_q;
  assign locked      = (state_q == LOCKED);
  assign err_count   = err_q;

endmodule

// File: tb/tb_johnson_decoder.sv
// tb/tb_johnson_decoder.sv - self-checking bench for johnson_decoder (N=4, LOCK_COUNT=2)
module tb_johnson_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] code_in = '0;
  logic       code_valid = 1'b0;
  logic       clr_err = 1'b0;

  logic [2:0] index_out, index_out2;
  logic       index_valid, index_valid2, illegal, illegal2, seq_err, seq_err2, locked, locked2;
  logic [7:0] err_count;
  logic [1:0] err_count2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  johnson_decoder #(.N(4), .LOCK_COUNT(2), .ALLOW_HOLD(1), .ERRW(8)) u_dut (
    .clk(clk), .rst(rst), .code_in(code_in), .code_valid(code_valid), .clr_err(clr_err),
    .index_out(index_out), .index_valid(index_valid), .illegal(illegal), .seq_err(seq_err),
    .locked(locked), .err_count(err_count)
  );

  johnson_decoder #(.N(4), .LOCK_COUNT(2), .ALLOW_HOLD(1), .ERRW(2)) u_dut2 (
    .clk(clk), .rst(rst), .code_in(code_in), .code_valid(code_valid), .clr_err(clr_err),
    .index_out(index_out2), .index_valid(index_valid2), .illegal(illegal2), .seq_err(seq_err2),
    .locked(locked2), .err_count(err_count2)
  );

  typedef struct {
    logic [3:0] code;
    logic       valid;
    logic       clr;
    int         e_idx;
    logic       e_iv;
    logic       e_ill;
    logic       e_seq;
    logic       e_lk;
    int         e_err;
  } vec_t;

  vec_t vecs[$];

  // Reference: the legal words listed by position in the 2N-state cycle.
  logic [3:0] jtab[8];
  bit         m_locked;
  int         m_run, m_prev, m_idx, m_err8, m_err2;
  bit         m_iv, m_ill, m_seq;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_main(input string tag, input int e_idx, input logic e_iv, input logic e_ill,
                            input logic e_seq, input logic e_lk, input int e_err);
    check({tag, " index_out"}, int'(index_out), e_idx);
    check({tag, " index_valid"}, int'(index_valid), int'(e_iv));
    check({tag, " illegal"}, int'(illegal), int'(e_ill));
    check({tag, " seq_err"}, int'(seq_err), int'(e_seq));
    check({tag, " locked"}, int'(locked), int'(e_lk));
    check({tag, " err_count"}, int'(err_count), e_err);
  endtask

  task automatic drive(input logic [3:0] c, input logic v, input logic clr);
    code_in    = c;
    code_valid = v;
    clr_err    = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    code_valid = 1'b0;
    clr_err    = 1'b0;
    rst        = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_locked = 0; m_run = 0; m_prev = -1; m_idx = 0; m_err8 = 0; m_err2 = 0;
    m_iv = 0; m_ill = 0; m_seq = 0;
  endtask

  task automatic model_step(input logic [3:0] c, input logic v, input logic clr);
    int  k;
    bit  succ, err_ev;
    k = -1;
    for (int i = 0; i < 8; i++) if (jtab[i] == c) k = i;
    m_iv = 0; m_ill = 0; m_seq = 0; err_ev = 0;
    if (v) begin
      if (k < 0) begin
        m_ill = 1; err_ev = 1; m_locked = 0; m_run = 0; m_prev = -1;
      end else begin
        m_iv  = 1;
        m_idx = k;
        succ  = (m_prev >= 0) && ((k == (m_prev + 1) % 8) || (k == m_prev));
        if (m_locked) begin
          if (!succ) begin m_seq = 1; err_ev = 1; m_locked = 0; m_run = 0; end
        end else if (succ) begin
          m_run++;
          if (m_run >= 2) m_locked = 1;
        end else begin
          m_run = 0;
        end
        m_prev = k;
      end
    end
    if (clr) begin
      m_err8 = 0; m_err2 = 0;
    end else if (err_ev) begin
      if (m_err8 < 255) m_err8++;
      if (m_err2 < 3) m_err2++;
    end
  endtask

  function automatic vec_t mk(input logic [3:0] c, input logic v, input logic clr, input int ei,
                              input logic eiv, input logic eill, input logic eseq, input logic elk,
                              input int eerr);
    vec_t r;
    r.code = c; r.valid = v; r.clr = clr; r.e_idx = ei; r.e_iv = eiv; r.e_ill = eill;
    r.e_seq = eseq; r.e_lk = elk; r.e_err = eerr;
    return r;
  endfunction

  initial begin
    int pos;
    logic [3:0] c;
    logic v, clr;

    for (int k = 0; k < 8; k++)
      jtab[k] = (k <= 4) ? 4'((1 << k) - 1) : (4'hF ^ 4'((1 << (k - 4)) - 1));

    // Full cycle, lock, jump, illegal, hold/wrap, clr-vs-error collision
    vecs.push_back(mk(4'b0000, 1, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(4'b0001, 1, 0, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(4'b0011, 1, 0, 2, 1, 0, 0, 1, 0));
    vecs.push_back(mk(4'b0111, 1, 0, 3, 1, 0, 0, 1, 0));
    vecs.push_back(mk(4'b1111, 1, 0, 4, 1, 0, 0, 1, 0));
    vecs.push_back(mk(4'b1110, 1, 0, 5, 1, 0, 0, 1, 0));
    vecs.push_back(mk(4'b1100, 1, 0, 6, 1, 0, 0, 1, 0));
    vecs.push_back(mk(4'b1000, 1, 0, 7, 1, 0, 0, 1, 0));
    vecs.push_back(mk(4'b0000, 1, 0, 0, 1, 0, 0, 1, 0));
    vecs.push_back(mk(4'b0001, 1, 0, 1, 1, 0, 0, 1, 0));
    vecs.push_back(mk(4'b0011, 1, 0, 2, 1, 0, 0, 1, 0));
    vecs.push_back(mk(4'b1110, 1, 0, 5, 1, 0, 1, 0, 1));
    vecs.push_back(mk(4'b0000, 0, 0, 5, 0, 0, 0, 0, 1));
    vecs.push_back(mk(4'b1100, 1, 0, 6, 1, 0, 0, 0, 1));
    vecs.push_back(mk(4'b1000, 1, 0, 7, 1, 0, 0, 1, 1));
    vecs.push_back(mk(4'b0101, 1, 0, 7, 0, 1, 0, 0, 2));
    vecs.push_back(mk(4'b1000, 1, 0, 7, 1, 0, 0, 0, 2));
    vecs.push_back(mk(4'b1000, 1, 0, 7, 1, 0, 0, 0, 2));
    vecs.push_back(mk(4'b0000, 1, 0, 0, 1, 0, 0, 1, 2));
    vecs.push_back(mk(4'b0001, 1, 0, 1, 1, 0, 0, 1, 2));
    vecs.push_back(mk(4'b1001, 1, 1, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(4'b0000, 1, 0, 0, 1, 0, 0, 0, 0));

    do_reset();
    check_main("reset", 0, 0, 0, 0, 0, 0);
    check("reset err_count2", int'(err_count2), 0);

    foreach (vecs[i]) begin
      drive(vecs[i].code, vecs[i].valid, vecs[i].clr);
      check_main($sformatf("vec%0d", i), vecs[i].e_idx, vecs[i].e_iv, vecs[i].e_ill,
                 vecs[i].e_seq, vecs[i].e_lk, vecs[i].e_err);
    end

    // Asynchronous reset while locked, then the first word must not flag seq_err
    do_reset();
    drive(4'b0000, 1, 0);
    drive(4'b0001, 1, 0);
    drive(4'b0011, 1, 0);
    drive(4'b0111, 1, 0);
    check("pre-rst locked", int'(locked), 1);
    #2 rst = 1'b1;
    #1;
    check_main("async rst", 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    drive(4'b1100, 1, 0);
    check_main("post-rst", 6, 1, 0, 0, 0, 0);

    // Saturation of the 2-bit error counter, then clear colliding with an error
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(4'b0110, 1, 0);
      check($sformatf("sat2 step%0d", i), int'(err_count2), (i < 3) ? i + 1 : 3);
      check($sformatf("sat8 step%0d", i), int'(err_count), i + 1);
    end
    drive(4'b1011, 1, 1);
    check("clr wins err_count2", int'(err_count2), 0);
    check("clr wins err_count", int'(err_count), 0);
    check("clr illegal pulse", int'(illegal2), 1);

    // Randomized stream against the reference model
    do_reset();
    pos = 0;
    for (int n = 0; n < 3000; n++) begin
      int r;
      v   = ($urandom_range(0, 7) != 0);
      clr = ($urandom_range(0, 39) == 0);
      r   = $urandom_range(0, 15);
      if (r <= 10) begin
        pos = (pos + 1) % 8; c = jtab[pos];
      end else if (r <= 12) begin
        c = jtab[pos];
      end else if (r == 13) begin
        pos = $urandom_range(0, 7); c = jtab[pos];
      end else begin
        c = 4'($urandom_range(0, 15));
      end
      drive(c, v, clr);
      model_step(c, v, clr);
      check_main($sformatf("rnd%0d", n), m_idx, m_iv, m_ill, m_seq, m_locked, m_err8);
      check($sformatf("rnd%0d err_count2", n), int'(err_count2), m_err2);
      check($sformatf("rnd%0d locked2", n), int'(locked2), int'(m_locked));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
